// File: rtl/sdram_aref_if.sv
// Arbiter-facing signal bundle of the SDRAM auto-refresh controller.
// The slave modport is the refresh block; the master modport is the arbiter/init side.
interface sdram_aref_if;
  logic        ar_en;
  logic        init_end;
  logic        ar_req;
  logic        ar_end;
  logic [3:0]  ar_cmd;
  logic [1:0]  ar_bank;
  logic [12:0] ar_addr;

  modport slave (
    input  ar_en, init_end,
    output ar_req, ar_end, ar_cmd, ar_bank, ar_addr
  );

  modport master (
    output ar_en, init_end,
    input  ar_req, ar_end, ar_cmd, ar_bank, ar_addr
  );
endinterface

// File: rtl/sdram_aref.sv
// SDRAM auto-refresh controller: periodic refresh request plus a
// PRECHARGE-all / AR_NUM x AUTO REFRESH command sequence once granted.
module sdram_aref #(
  parameter int REF_MAX  = 750,
  parameter int TRP_CLK  = 2,
  parameter int TRFC_CLK = 7,
  parameter int AR_NUM   = 2
) (
  input  logic         ar_clk,
  input  logic         ar_rst,
  sdram_aref_if.slave  bus
);

  localparam int RW   = $clog2(REF_MAX);
  localparam int WMAX = (TRP_CLK > TRFC_CLK) ? TRP_CLK : TRFC_CLK;
  localparam int WW   = $clog2(WMAX + 1);
  localparam int ARW  = $clog2(AR_NUM + 1);

  localparam logic [RW-1:0]  REF_LAST  = RW'(REF_MAX - 1);
  localparam logic [WW-1:0]  TRP_LAST  = WW'(TRP_CLK - 1);
  localparam logic [WW-1:0]  TRFC_LAST = WW'(TRFC_CLK - 1);
  localparam logic [ARW-1:0] AR_TOTAL  = ARW'(AR_NUM);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    PRE  = 3'b001,
    TRP  = 3'b011,
    AR   = 3'b010,
    TRFC = 3'b110,
    END  = 3'b111
  } state_t;

  state_t         state_curr, state_next;
  logic [RW-1:0]  ref_cnt_q, ref_cnt_d;
  logic [WW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [ARW-1:0] ar_cnt_q, ar_cnt_d;
  logic           ar_req_q, ar_req_d;

  always_ff @(posedge ar_clk or posedge ar_rst) begin
    if (ar_rst) begin
      state_curr <= IDLE;
      ref_cnt_q  <= '0;
      wait_cnt_q <= '0;
      ar_cnt_q   <= '0;
      ar_req_q   <= 1'b0;
    end else begin
      state_curr <= state_next;
      ref_cnt_q  <= ref_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      ar_cnt_q   <= ar_cnt_d;
      ar_req_q   <= ar_req_d;
    end
  end

  // Interval counter free-runs through sequences; a new interval setting ar_req beats a grant clearing it.
  always_comb begin
    ref_cnt_d = ref_cnt_q;
    ar_req_d  = ar_req_q;
    if (!bus.init_end) begin
      ref_cnt_d = '0;
      ar_req_d  = 1'b0;
    end else begin
      if (ref_cnt_q == REF_LAST) begin
        ref_cnt_d = '0;
        ar_req_d  = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q + 1'b1;
        if (bus.ar_en) begin
          ar_req_d = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_next = state_curr;
    ar_cnt_d   = ar_cnt_q;
    wait_cnt_d = '0;
    unique case (state_curr)
      IDLE: begin
        ar_cnt_d = '0;
        if (bus.ar_en && bus.init_end) begin
          state_next = PRE;
        end
      end
      PRE:  state_next = TRP;
      TRP: begin
        if (wait_cnt_q == TRP_LAST) begin
          state_next = AR;
        end
      end
      AR: begin
        ar_cnt_d   = ar_cnt_q + 1'b1;
        state_next = TRFC;
      end
      TRFC: begin
        if (wait_cnt_q == TRFC_LAST) begin
          state_next = (ar_cnt_q == AR_TOTAL) ? END : AR;
        end
      end
      END:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Wait counter only accumulates while parked in a timed state.
    if ((state_next == state_curr) && ((state_curr == TRP) || (state_curr == TRFC))) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_comb begin
    bus.ar_cmd = CMD_NOP;
    unique case (state_curr)
      PRE:     bus.ar_cmd = CMD_PRE;
      AR:      bus.ar_cmd = CMD_AREF;
      default: bus.ar_cmd = CMD_NOP;
    endcase
  end

  // A10 high in the address makes PRECHARGE hit all banks.
  assign bus.ar_bank = 2'b11;
  assign bus.ar_addr = 13'h1FFF;
  assign bus.ar_end  = (state_curr == END);
  assign bus.ar_req  = ar_req_q;

endmodule

// File: tb/tb_sdram_aref.sv
// Scoreboard bench for sdram_aref: stimulus queues expected output events,
// an independent negedge monitor pops and compares them.
module tb_sdram_aref;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PREC = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;

  typedef struct {
    int         cyc;
    logic [3:0] cmd;
    logic       endp;
    logic       req;
  } evt_t;

  logic ar_clk;
  logic ar_rst;
  int   cyc = 0;
  int   testsRun = 0;
  int   testsFailed = 0;
  logic prevReq = 1'b0;
  evt_t expQ[$];

  sdram_aref_if bus();

  sdram_aref dut (
    .ar_clk (ar_clk),
    .ar_rst (ar_rst),
    .bus    (bus)
  );

  initial ar_clk = 1'b0;
  always #5 ar_clk = ~ar_clk;
  always @(posedge ar_clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic initDone);
    bus.ar_en    = en;
    bus.init_end = initDone;
  endtask

  task automatic waitCycle(input int t);
    while (cyc < t) begin
      @(posedge ar_clk);
      #1;
    end
  endtask

  task automatic pushEvt(input int c, input logic [3:0] cmd, input logic e, input logic r);
    evt_t ev;
    ev.cyc  = c;
    ev.cmd  = cmd;
    ev.endp = e;
    ev.req  = r;
    expQ.push_back(ev);
  endtask

  // Full default sequence after ar_en goes high at cycle g: PRE, NOP x2, AREF, NOP x7, AREF, NOP x7, END.
  task automatic pushSeq(input int g, input logic reqAtPre);
    pushEvt(g + 1, PREC, 1'b0, reqAtPre);
    if (reqAtPre) pushEvt(g + 2, NOP, 1'b0, 1'b0);
    pushEvt(g + 4,  AREF, 1'b0, 1'b0);
    pushEvt(g + 12, AREF, 1'b0, 1'b0);
    pushEvt(g + 20, NOP,  1'b1, 1'b0);
  endtask

  task automatic waitEndAndRelease(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge ar_clk);
      if (bus.ar_end) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(name, {31'd0, seen}, 32'd1);
    @(posedge ar_clk);
    #1;
    applyStimulus(1'b0, bus.init_end);
  endtask

  always @(negedge ar_clk) begin
    logic isEvt;
    evt_t ev;
    isEvt   = (bus.ar_cmd != NOP) || bus.ar_end || (bus.ar_req != prevReq);
    prevReq = bus.ar_req;
    checkOutput("bank", {30'd0, bus.ar_bank}, 32'd3);
    checkOutput("addr", {19'd0, bus.ar_addr}, 32'h1FFF);
    if (isEvt) begin
      testsRun++;
      if (expQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL unexpected_evt: cyc=%0d cmd=%h end=%b req=%b, expected no event",
                 cyc, bus.ar_cmd, bus.ar_end, bus.ar_req);
      end else begin
        ev = expQ.pop_front();
        if ((ev.cyc != cyc) || (ev.cmd !== bus.ar_cmd) || (ev.endp !== bus.ar_end) ||
            (ev.req !== bus.ar_req)) begin
          testsFailed++;
          $display("[TB] FAIL evt: got cyc=%0d cmd=%h end=%b req=%b, expected cyc=%0d cmd=%h end=%b req=%b",
                   cyc, bus.ar_cmd, bus.ar_end, bus.ar_req, ev.cyc, ev.cmd, ev.endp, ev.req);
        end
      end
    end
  end

  initial begin
    int c0, g, r, q;
    ar_rst = 1'b1;
    applyStimulus(1'b0, 1'b1);
    repeat (3) @(posedge ar_clk);
    #1;
    checkOutput("rst_req",   {31'd0, bus.ar_req}, 32'd0);
    checkOutput("rst_end",   {31'd0, bus.ar_end}, 32'd0);
    checkOutput("rst_cmd",   {28'd0, bus.ar_cmd}, 32'h7);
    checkOutput("rst_state", 32'(dut.state_curr), 32'd0);

    @(posedge ar_clk);
    #1;
    ar_rst = 1'b0;
    c0 = cyc;
    pushEvt(c0 + 750, NOP, 1'b0, 1'b1);

    // First interval, granted one cycle after the request.
    waitCycle(c0 + 751);
    g = cyc;
    applyStimulus(1'b1, 1'b1);
    pushSeq(g, 1'b0);
    waitEndAndRelease("end_seen_1");

    // Grant withheld for 800 cycles: request must stay high across the next set point.
    pushEvt(c0 + 1500, NOP, 1'b0, 1'b1);
    waitCycle(c0 + 2300);
    g = cyc;
    applyStimulus(1'b1, 1'b1);
    pushSeq(g, 1'b0);
    waitEndAndRelease("end_seen_2");

    // Grant sampled on the same edge the counter sets the request.
    waitCycle(c0 + 2999);
    g = cyc;
    applyStimulus(1'b1, 1'b1);
    pushSeq(g, 1'b1);
    waitEndAndRelease("end_seen_3");

    // Grant with initialisation incomplete, spanning a would-be request point.
    waitCycle(c0 + 3100);
    applyStimulus(1'b1, 1'b0);
    waitCycle(c0 + 3400);
    checkOutput("noinit_state", 32'(dut.state_curr), 32'd0);
    waitCycle(c0 + 3800);
    r = cyc;
    applyStimulus(1'b0, 1'b1);
    pushEvt(r + 750, NOP, 1'b0, 1'b1);

    // Sequence disturbed by ar_en/init_end drops, then aborted by reset in TRFC.
    waitCycle(r + 751);
    g = cyc;
    applyStimulus(1'b1, 1'b1);
    pushEvt(g + 1, PREC, 1'b0, 1'b0);
    pushEvt(g + 4, AREF, 1'b0, 1'b0);
    waitCycle(g + 2);
    applyStimulus(1'b0, 1'b0);
    waitCycle(g + 5);
    applyStimulus(1'b0, 1'b1);
    waitCycle(g + 7);
    checkOutput("trfc_state", 32'(dut.state_curr), 32'h6);
    ar_rst = 1'b1;
    #1;
    checkOutput("abort_state", 32'(dut.state_curr), 32'd0);
    checkOutput("abort_cmd",   {28'd0, bus.ar_cmd}, 32'h7);
    checkOutput("abort_end",   {31'd0, bus.ar_end}, 32'd0);
    waitCycle(g + 9);
    ar_rst = 1'b0;
    q = cyc;
    pushEvt(q + 750, NOP, 1'b0, 1'b1);
    waitCycle(q + 760);

    checkOutput("queue_drain", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sdram_aref.md
SDRAM_AREF -- requirements
Module: sdram_aref

Interface
REQ-001 Parameter REF_MAX, default 750: refresh interval in clocks, 7.5 us at 100 MHz.
REQ-002 Parameter TRP_CLK, default 2: precharge-to-command wait in clocks.
REQ-003 Parameter TRFC_CLK, default 7: auto-refresh recovery wait in clocks.
REQ-004 Parameter AR_NUM, default 2: number of AUTO REFRESH commands per sequence.
REQ-005 ar_clk  in  1  single clock; all state updates on its rising edge.
REQ-006 ar_rst  in  1  reset, asynchronous, active-high.
REQ-007 ar_en  in  1  grant from arbiter; held high by arbiter from grant until ar_end.
REQ-008 init_end  in  1  high once SDRAM power-up initialisation is complete.
REQ-009 ar_req  out  1  refresh request to arbiter.
REQ-010 ar_end  out  1  one-cycle pulse marking completion of the refresh sequence.
REQ-011 ar_cmd  out  4  SDRAM command {cs_n,ras_n,cas_n,we_n}.
REQ-012 ar_bank  out  2  bank address.
REQ-013 ar_addr  out  13  row/column address.

Function
REQ-014 Command encodings SHALL be NOP=4'b0111, PRECHARGE=4'b0010, AUTO REFRESH=4'b0001.
REQ-015 Refresh counter SHALL be held at 0 while init_end=0, and otherwise increment each clock, wrapping from REF_MAX-1 to 0; it SHALL free-run during refresh sequences.
REQ-016 ar_req SHALL be set on the clock where the counter equals REF_MAX-1.
REQ-017 ar_req SHALL be cleared on the first clock on which ar_en=1 is sampled.
REQ-018 If set and clear conditions of ar_req coincide, set SHALL win.
REQ-019 ar_req SHALL remain 0 while init_end=0.
REQ-020 FSM state encodings SHALL be IDLE=3'b000, PRE=3'b001, TRP=3'b011, AR=3'b010, TRFC=3'b110, END=3'b111; the state register SHALL be named state_curr.
REQ-021 Transition IDLE->PRE SHALL occur when ar_en=1 and init_end=1; otherwise the FSM stays in IDLE.
REQ-022 PRE SHALL last 1 clock, then go to TRP.
REQ-023 TRP SHALL last TRP_CLK clocks, then go to AR.
REQ-024 AR SHALL last 1 clock, then go to TRFC.
REQ-025 An AR-issue counter SHALL increment once per AR cycle and be cleared in IDLE.
REQ-026 TRFC SHALL last TRFC_CLK clocks, then go to END if AR_NUM AUTO REFRESH commands have been issued, else back to AR.
REQ-027 END SHALL last 1 clock, then go to IDLE.
REQ-028 A wait-cycle counter SHALL clear on every state change and count clocks within TRP/TRFC.
REQ-029 ar_cmd SHALL be decoded combinationally from state_curr: PRECHARGE in PRE, AUTO REFRESH in AR, NOP in all other states.
REQ-030 ar_bank SHALL be 2'b11 and ar_addr SHALL be 13'h1FFF in all states (A10=1 selects precharge all banks).
REQ-031 ar_end SHALL be 1 exactly in END, else 0.
REQ-032 With defaults, the sequence SHALL take 20 clocks from PRE entry through END inclusive.
REQ-033 ar_en deasserting mid-sequence and init_end falling mid-sequence SHALL NOT abort the sequence; only reset aborts it.
REQ-034 ar_en=1 sampled in states other than IDLE SHALL be ignored.

Reset
REQ-035 On ar_rst=1, asynchronously: state_curr=IDLE, all counters=0, ar_req=0, ar_end=0, ar_cmd=NOP, ar_bank=2'b11, ar_addr=13'h1FFF.
REQ-036 Reset asserted mid-sequence SHALL abort immediately to IDLE with no further commands issued.
REQ-037 After release, the refresh interval SHALL restart from 0 once init_end=1.

Verification
REQ-038 Release reset, init_end=1 at cycle 0 -> ar_req rises after 750 clocks; ar_cmd stays NOP throughout.
REQ-039 Grant on ar_req (ar_en registered, cleared on ar_end) -> ar_req clears; command sequence PRE, NOP x2, AREF, NOP x7, AREF, NOP x7, NOP with ar_end=1; ar_bank=3, ar_addr=1FFF throughout.
REQ-040 ar_en high while init_end=0 -> FSM stays IDLE, ar_req=0, only NOP issued.
REQ-041 ar_rst pulsed during TRFC -> ar_cmd=NOP immediately and state_curr=IDLE; next ar_req arrives 750 clocks after release.
REQ-042 Withhold grant for 800 clocks -> ar_req stays high continuously; the sequence then runs once and ar_end pulses for exactly 1 clock.
REQ-043 Bench with the SDRAM model -> command monitor shows PRECHARGE followed by two AUTO REFRESH per interval, with no timing violations.
